uart_cmd_ctrl: RTL and testbench

Command-frame controller downstream of the UART receiver in the pattern-generator FPGA. It consumes the receiver's byte stream (data plus one-cycle data-enable) and parses fixed 4-byte frames. Each valid frame becomes a single-cycle register write to the pattern-generator configuration bus. Malformed or stalled frames are discarded, flagged, and counted.

---
 rtl/uart_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command-frame parser behind the UART receiver: SYNC/ADDR/DATA/SUM frames become
// single-cycle configuration writes; checksum failures and inter-byte stalls are flagged and counted.
module uart_cmd_ctrl #(
  parameter int unsigned        TMO_WID = 20,
  parameter logic [TMO_WID-1:0] TMO_CNT = 20'd270000,
  parameter logic [7:0]         SYNC    = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_dataen,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_err,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } state_t;

  // The counter restarts at 0 in the cycle after a byte, so the stall decision is
  // taken when it holds TMO_CNT-2; the registered o_err then lands TMO_CNT cycles after that byte.
  localparam logic [TMO_WID-1:0] TMO_LAST = TMO_CNT - TMO_WID'(2);

  function automatic logic [7:0] frame_sum(input logic [7:0] addr, input logic [7:0] data);
    frame_sum = addr + data;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [TMO_WID-1:0] tmo_cnt_r;
  logic [TMO_WID-1:0] tmo_cnt_s;
  logic [7:0]         addr_r;
  logic [7:0]         addr_s;
  logic [7:0]         data_r;
  logic [7:0]         data_s;
  logic               we_s;
  logic               err_s;
  logic [7:0]         reg_addr_r;
  logic [7:0]         reg_wdata_r;
  logic               reg_we_r;
  logic               err_r;
  logic [7:0]         err_cnt_r;
  logic               busy_r;

  // Next state, payload capture, checksum verdict and stall detection
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    data_s    = data_r;
    tmo_cnt_s = '0;
    we_s      = 1'b0;
    err_s     = 1'b0;
    if (state_r == ST_IDLE) begin
      if (i_rx_dataen && (i_rx_data == SYNC)) begin
        state_s = ST_ADDR;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (i_rx_dataen) begin
      // A byte always beats a coincident timeout; SYNC here is ordinary payload.
      case (state_r)
        ST_ADDR: begin
          addr_s  = i_rx_data;
          state_s = ST_DATA;
        end
        ST_DATA: begin
          data_s  = i_rx_data;
          state_s = ST_SUM;
        end
        ST_SUM: begin
          if (i_rx_data == frame_sum(addr_r, data_r)) begin
            we_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (tmo_cnt_r == TMO_LAST) begin
      err_s   = 1'b1;
      state_s = ST_IDLE;
    end else begin
      tmo_cnt_s = tmo_cnt_r + TMO_WID'(1);
    end
  end

  // State, payload and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= '0;
      addr_r      <= 8'h00;
      data_r      <= 8'h00;
      reg_addr_r  <= 8'h00;
      reg_wdata_r <= 8'h00;
      reg_we_r    <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      tmo_cnt_r <= tmo_cnt_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      reg_we_r  <= we_s;
      err_r     <= err_s;
      busy_r    <= (state_s != ST_IDLE);
      if (we_s) begin
        reg_addr_r  <= addr_r;
        reg_wdata_r <= data_r;
      end
      if (err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign o_reg_addr  = reg_addr_r;
  assign o_reg_wdata = reg_wdata_r;
  assign o_reg_we    = reg_we_r;
  assign o_err       = err_r;
  assign o_err_cnt   = err_cnt_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a frame-level reference model predicts write/error
// pulses and per-cycle output state; a negedge monitor compares against the DUT.
module tb_uart_cmd_ctrl;

  localparam int         TMO  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       err;
  logic [7:0] err_cnt;
  logic       busy;

  uart_cmd_ctrl #(.TMO_WID(20), .TMO_CNT(20'd100), .SYNC(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_dataen(rx_en),
    .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata), .o_reg_we(reg_we),
    .o_err(err), .o_err_cnt(err_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {int c; bit we; bit er; logic [7:0] a; logic [7:0] d; logic [7:0] n;} ev_t;
  typedef struct {int c; bit b; logic [7:0] a; logic [7:0] d; logic [7:0] n;} st_t;
  ev_t ev_q[$];
  st_t st_q[$];

  int checks = 0;
  int errors = 0;

  // reference model: the bytes of the frame collected so far plus last-byte time
  logic [7:0] frm[$];
  int         last_c = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_cnt = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_err(input int c);
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    ev_q.push_back('{c: c + 1, we: 1'b0, er: 1'b1, a: m_addr, d: m_data, n: m_cnt});
    frm.delete();
  endtask

  task automatic model_step(input int c, input bit en, input logic [7:0] b);
    logic [7:0] s;
    if (en) begin
      if (frm.size() == 0) begin
        if (b == SYNC) begin
          frm.push_back(b);
          last_c = c;
        end
      end else begin
        frm.push_back(b);
        last_c = c;
        if (frm.size() == 4) begin
          s = frm[1] + frm[2];
          if (frm[3] == s) begin
            m_addr = frm[1];
            m_data = frm[2];
            ev_q.push_back('{c: c + 1, we: 1'b1, er: 1'b0, a: m_addr, d: m_data, n: m_cnt});
            frm.delete();
          end else begin
            model_err(c);
          end
        end
      end
    end else if ((frm.size() != 0) && (c - last_c == TMO - 1)) begin
      model_err(c);
    end
    st_q.push_back('{c: c + 1, b: (frm.size() != 0), a: m_addr, d: m_data, n: m_cnt});
  endtask

  task automatic step(input bit en, input logic [7:0] b);
    @(negedge clk);
    rx_en = en;
    rx_data = b;
    model_step(cyc, en, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step(1'b0, 8'($urandom));
    step(1'b1, b);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] s, input int gmax);
    send(SYNC, $urandom_range(0, gmax));
    send(a, $urandom_range(0, gmax));
    send(d, $urandom_range(0, gmax));
    send(s, $urandom_range(0, gmax));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_en = 1'b0;
    rx_data = 8'h00;
    frm.delete();
    ev_q.delete();
    st_q.delete();
    m_addr = 8'h00;
    m_data = 8'h00;
    m_cnt = 8'h00;
    @(negedge clk);
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_wdata", 32'(reg_wdata), 32'h0);
    chk("rst_we", 32'(reg_we), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
  endtask

  // monitor: pulses against the event queue, held outputs against per-cycle state
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we || err) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, reg_we, err}, 32'h0);
        end else begin
          chk("pulse_cycle", 32'(cyc), 32'(ev_q[0].c));
          chk("pulse_kind", {30'd0, reg_we, err}, {30'd0, ev_q[0].we, ev_q[0].er});
          chk("pulse_addr", 32'(reg_addr), 32'(ev_q[0].a));
          chk("pulse_wdata", 32'(reg_wdata), 32'(ev_q[0].d));
          chk("pulse_errcnt", 32'(err_cnt), 32'(ev_q[0].n));
          void'(ev_q.pop_front());
        end
      end else if ((ev_q.size() != 0) && (ev_q[0].c <= cyc)) begin
        chk("missing_pulse", {30'd0, reg_we, err}, {30'd0, ev_q[0].we, ev_q[0].er});
        void'(ev_q.pop_front());
      end
      while ((st_q.size() != 0) && (st_q[0].c < cyc)) void'(st_q.pop_front());
      if ((st_q.size() != 0) && (st_q[0].c == cyc)) begin
        chk("busy", 32'(busy), 32'(st_q[0].b));
        chk("hold_addr", 32'(reg_addr), 32'(st_q[0].a));
        chk("hold_wdata", 32'(reg_wdata), 32'(st_q[0].d));
        chk("errcnt", 32'(err_cnt), 32'(st_q[0].n));
        void'(st_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] s;
    do_reset();
    // directed cases
    frame(8'h12, 8'h34, 8'h46, 2);
    frame(8'h12, 8'h34, 8'h47, 2);
    frame(8'h01, 8'h02, 8'h03, 0);
    send(8'h00, 1); send(8'hFF, 0); send(8'h3C, 2);
    frame(8'hF0, 8'h20, 8'h10, 1);
    // stall after ADDR, then late bytes
    send(SYNC, 1); send(8'h12, 0);
    repeat (TMO) step(1'b0, 8'($urandom));
    send(8'h34, 0); send(8'h46, 0);
    // bytes arriving exactly on the last allowed cycle
    send(SYNC, 2); send(8'h11, TMO - 2); send(8'h22, TMO - 2); send(8'h33, TMO - 2);
    // randomized frames with garbage, bad sums and occasional long gaps
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      s = a + d;
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 4) == 0) send(8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        send(SYNC, 0);
        send(a, TMO - 3 + $urandom_range(0, 3));
        send(d, 0);
        send(s, $urandom_range(0, 2));
      end else begin
        frame(a, d, s, 3);
      end
    end
    // saturate the error counter with back-to-back bad frames
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      s = a + d + 8'd1;
      frame(a, d, s, 0);
    end
    step(1'b0, 8'h00);
    chk("errcnt_sat", 32'(err_cnt), 32'hFF);
    // reset in the middle of a frame
    send(SYNC, 0); send(8'h12, 0);
    do_reset();
    frame(8'h07, 8'h08, 8'h0F, 0);
    repeat (5) step(1'b0, 8'($urandom));
    chk("final_addr", 32'(reg_addr), 32'h07);
    chk("final_wdata", 32'(reg_wdata), 32'h08);
    chk("drain", 32'(ev_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
